// File: rtl/operand_skewer.sv
// Transmit side of the systolic array operand interface: buffers an A/B
// matrix pair, then emits diagonally skewed, zero-padded wavefronts.
module operand_skewer #(
   parameter int N        = 4,
   parameter int NUM_BITS = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  ld_valid_i,
   output logic                  ld_ready_o,
   input  logic [N*NUM_BITS-1:0] a_row_i,
   input  logic [N*NUM_BITS-1:0] b_col_i,
   output logic [N*NUM_BITS-1:0] north_o,
   output logic [N*NUM_BITS-1:0] west_o,
   output logic                  stream_vld_o,
   output logic                  done_o
);

   localparam int TW = $clog2(3*N-2);
   localparam int BW = $clog2(N) + 1;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [TW-1:0] T_LAST    = TW'(3*N-3);
   localparam logic [BW-1:0] BEAT_LAST = BW'(N-1);

   typedef enum logic [1:0] {S_LOAD, S_STREAM, S_DONE} state_t;

   state_t                r_state, w_state_nxt;
   logic [BW-1:0]         r_cnt;
   logic [TW-1:0]         r_t;
   logic                  r_fin;
   logic [N*NUM_BITS-1:0] r_north, r_west;
   logic                  r_vld, r_done;
   logic [N*NUM_BITS-1:0] w_north, w_west;
   logic                  w_accept;

   logic [NUM_BITS-1:0]   r_a [N][N];
   logic [NUM_BITS-1:0]   r_b [N][N];

   assign ld_ready_o = (r_state == S_LOAD);
   assign w_accept   = ld_ready_o && ld_valid_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_LOAD;
      else       r_state <= w_state_nxt;
   end

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_LOAD:   if (w_accept && r_cnt == BEAT_LAST) w_state_nxt = S_STREAM;
         S_STREAM: if (r_fin) w_state_nxt = S_DONE;
         S_DONE:   w_state_nxt = S_LOAD;
         default:  w_state_nxt = S_LOAD;
      endcase
   end

   // NOTE: the operand buffers carry no reset; they are always fully rewritten before being read.
   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         for (int k = 0; k < N; k++) begin
            r_a[r_cnt[IW-1:0]][k] <= a_row_i[(N-1-k)*NUM_BITS +: NUM_BITS];
            r_b[k][r_cnt[IW-1:0]] <= b_col_i[(N-1-k)*NUM_BITS +: NUM_BITS];
         end
      end
   end

   // Lane i of wavefront t carries element index t-i, or zero outside the matrix.
   always_comb begin
      w_west  = '0;
      w_north = '0;
      for (int i = 0; i < N; i++) begin
         if ((int'(r_t) >= i) && (int'(r_t) - i < N)) begin
            w_west [(N-1-i)*NUM_BITS +: NUM_BITS] = r_a[i][IW'(int'(r_t) - i)];
            w_north[(N-1-i)*NUM_BITS +: NUM_BITS] = r_b[IW'(int'(r_t) - i)][i];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt   <= '0;
         r_t     <= '0;
         r_fin   <= 1'b0;
         r_north <= '0;
         r_west  <= '0;
         r_vld   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_north <= '0;
         r_west  <= '0;
         r_vld   <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            S_LOAD: begin
               if (w_accept) begin
                  r_cnt <= (r_cnt == BEAT_LAST) ? '0 : r_cnt + 1'b1;
                  r_t   <= '0;
                  r_fin <= 1'b0;
               end
            end
            S_STREAM: begin
               if (r_fin) begin
                  r_done <= 1'b1;
               end else begin
                  r_north <= w_north;
                  r_west  <= w_west;
                  r_vld   <= 1'b1;
                  if (r_t == T_LAST) r_fin <= 1'b1;
                  else               r_t   <= r_t + 1'b1;
               end
            end
            default: begin
               r_cnt <= '0;
               r_t   <= '0;
               r_fin <= 1'b0;
            end
         endcase
      end
   end

   assign north_o      = r_north;
   assign west_o       = r_west;
   assign stream_vld_o = r_vld;
   assign done_o       = r_done;

endmodule
